// File: rtl/sram_streamer_pkg.sv
// Shared definitions for the SRAM read streamer.
//   state_t           : controller states (IDLE, ISSUE, DRAIN, FINISH)
//   fifo_count_w()    : bits needed to hold a FIFO occupancy of 0..depth
//   inflight_count_w(): bits needed to count the registered read plus a
//                       latency-deep pipe of outstanding reads (0..latency+1)
package sram_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    function automatic int fifo_count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int inflight_count_w(input int latency);
        return $clog2(latency + 2);
    endfunction

endpackage

// File: rtl/sram_stream_fifo.sv
// Synchronous FIFO holding returned SRAM words (data plus last tag).
// Ports:
//   clka, rstb          : clock, async active-low reset
//   push, push_data     : write one entry
//   pop                 : remove the head entry (ignored when empty)
//   head_data           : current head entry, valid while !empty
//   count, full, empty  : occupancy status
module sram_stream_fifo
    import sram_streamer_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                           clka,
    input  logic                           rstb,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_data,
    output logic [fifo_count_w(DEPTH)-1:0] count,
    output logic                           full,
    output logic                           empty
);

    localparam int CW = fifo_count_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clka or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The issue credit in the streamer must make this unreachable.
    a_no_overflow: assert property (@(posedge clka) disable iff (!rstb)
        !(push && full && !pop));

endmodule

// File: rtl/sram_read_streamer.sv
// Walks an address range on the SRAM read port and presents the returned
// words as a valid/ready stream. Reads are only issued when the FIFO is
// guaranteed room for them, so consumer stalls never lose a word.
// Ports:
//   clka, rstb                  : clock, async active-low reset
//   start, base_addr, num_words : transfer request (sampled in IDLE)
//   busy, done                  : transfer status, done is a 1-cycle pulse
//   sram_enb, sram_addrb        : SRAM read request (registered)
//   sram_doutb                  : SRAM read data, READ_LATENCY after sram_enb
//   m_valid, m_data, m_last     : stream output (FIFO head)
//   m_ready                     : stream consumer ready
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | issuing reads while credit and remaining words allow
// DRAIN  | all reads issued, waiting for the last beat to be accepted
// FINISH | done pulse, back to IDLE next cycle
module sram_read_streamer
    import sram_streamer_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int BUFFER_DEPTH = 128,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clka,
    input  logic                  rstb,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_enb,
    output logic [ADDR_WIDTH-1:0] sram_addrb,
    input  logic [DATA_WIDTH-1:0] sram_doutb,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int FCW = fifo_count_w(FIFO_DEPTH);
    localparam int IFW = inflight_count_w(READ_LATENCY);
    localparam logic [ADDR_WIDTH:0] ONE_WORD = (ADDR_WIDTH + 1)'(1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_ptr;
    logic [ADDR_WIDTH:0]     remaining;
    logic                    enb_last;
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [READ_LATENCY-1:0] pipe_last;

    logic [FCW-1:0]          fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DATA_WIDTH:0]     fifo_head;
    logic                    pop;
    logic                    head_last;
    logic [IFW-1:0]          inflight_count;
    logic                    credit_ok;
    logic [ADDR_WIDTH-1:0]   base_cap;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) == 32'(BUFFER_DEPTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    assign base_cap = (32'(base_addr) >= 32'(BUFFER_DEPTH)) ? '0 : base_addr;

    // Outstanding reads: the one on the SRAM port now plus the latency pipe.
    always_comb begin
        inflight_count = IFW'(sram_enb);
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_count = inflight_count + IFW'(pipe_vld[i]);
        end
    end

    // A pop in this cycle earns no credit; keeps the FIFO bound simple.
    assign credit_ok = !fifo_full &&
        ((32'(fifo_count) + 32'(inflight_count)) < 32'(FIFO_DEPTH));

    assign m_valid   = !fifo_empty;
    assign m_data    = fifo_head[DATA_WIDTH-1:0];
    assign head_last = fifo_head[DATA_WIDTH];
    assign m_last    = m_valid && head_last;
    assign pop       = m_valid && m_ready;

    always_ff @(posedge clka or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            sram_enb   <= 1'b0;
            sram_addrb <= '0;
            addr_ptr   <= '0;
            remaining  <= '0;
            enb_last   <= 1'b0;
        end else begin
            sram_enb <= 1'b0;
            enb_last <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (num_words == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            // FIFO is empty here, so the first read goes out at once.
                            state      <= ISSUE;
                            sram_enb   <= 1'b1;
                            sram_addrb <= base_cap;
                            addr_ptr   <= next_addr(base_cap);
                            remaining  <= num_words - ONE_WORD;
                            enb_last   <= (num_words == ONE_WORD);
                        end
                    end
                end
                ISSUE: begin
                    // remaining excludes the read currently on the port.
                    if (remaining == '0) begin
                        state <= DRAIN;
                    end else if (credit_ok) begin
                        sram_enb   <= 1'b1;
                        sram_addrb <= addr_ptr;
                        addr_ptr   <= next_addr(addr_ptr);
                        remaining  <= remaining - ONE_WORD;
                        enb_last   <= (remaining == ONE_WORD);
                    end
                end
                DRAIN: begin
                    if (pop && head_last) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clka or negedge rstb) begin
        if (!rstb) begin
            pipe_vld  <= '0;
            pipe_last <= '0;
        end else begin
            pipe_vld[0]  <= sram_enb;
            pipe_last[0] <= sram_enb && enb_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
        end
    end

    sram_stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clka      (clka),
        .rstb      (rstb),
        .push      (pipe_vld[READ_LATENCY-1]),
        .push_data ({pipe_last[READ_LATENCY-1], sram_doutb}),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_sram_read_streamer.sv
module tb_sram_read_streamer;

    logic       clka = 1'b0;
    logic       rstb;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] num_words;
    logic       busy;
    logic       done;
    logic       sram_enb;
    logic [7:0] sram_addrb;
    logic [7:0] sram_doutb = 8'h00;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_cyc = 0;
    int rd_count = 0;
    int ready_mode = 0;   // 0: high, 1: random, 2: low
    bit mon_en = 1'b1;

    logic [7:0] addr_q[$];
    logic [8:0] exp_q[$];

    sram_read_streamer dut (
        .clka       (clka),
        .rstb       (rstb),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .busy       (busy),
        .done       (done),
        .sram_enb   (sram_enb),
        .sram_addrb (sram_addrb),
        .sram_doutb (sram_doutb),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    always #5 clka = ~clka;

    always @(posedge clka) cyc <= cyc + 1;

    // SRAM model, one cycle read latency
    always @(posedge clka) if (sram_enb) sram_doutb <= sram_addrb ^ 8'hA5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clka);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard monitor: read addresses and stream beats against queues.
    always @(negedge clka) begin
        if (rstb && mon_en) begin
            if (sram_enb) begin
                rd_count++;
                if (addr_q.size() == 0) check("extra_read", 32'(addr_q.size()), 32'd1);
                else check("read_addr", 32'(sram_addrb), 32'(addr_q.pop_front()));
            end
            if (m_valid) begin
                if (exp_q.size() == 0) check("extra_beat", 32'(exp_q.size()), 32'd1);
                else begin
                    check("m_data", 32'(m_data), 32'(exp_q[0][7:0]));
                    check("m_last", 32'(m_last), 32'(exp_q[0][8]));
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        if (m_last) last_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic pulse_start(input logic [7:0] b, input logic [8:0] n);
        @(posedge clka);
        #1;
        base_addr = b;
        num_words = n;
        start     = 1'b1;
        @(posedge clka);
        #1;
        start = 1'b0;
    endtask

    task automatic start_xfer(input logic [7:0] b, input logic [8:0] n);
        int a;
        a = (int'(b) >= 128) ? 0 : int'(b);
        for (int i = 0; i < int'(n); i++) begin
            addr_q.push_back(8'(a));
            exp_q.push_back({(i == int'(n) - 1), 8'(a) ^ 8'hA5});
            a = (a + 1) % 128;
        end
        pulse_start(b, n);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clka);
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(done), 32'd1);
        if (seen) check("done_timing", 32'(cyc), 32'(last_cyc + 1));
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("addr_q_empty", 32'(addr_q.size()), 32'd0);
        @(negedge clka);
        check("done_pulse", 32'(done), 32'd0);
        check("busy_clear", 32'(busy), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_enb"}, 32'(sram_enb), 32'd0);
        check({tag, "_addrb"}, 32'(sram_addrb), 32'd0);
        check({tag, "_mvalid"}, 32'(m_valid), 32'd0);
        check({tag, "_mlast"}, 32'(m_last), 32'd0);
        check({tag, "_mdata"}, 32'(m_data), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int rd0;
        bit seen;
        rstb      = 1'b0;
        start     = 1'b0;
        base_addr = 8'h00;
        num_words = 9'd0;
        repeat (3) @(posedge clka);
        #2;
        check_idle_outputs("reset");
        @(posedge clka);
        #1 rstb = 1'b1;
        repeat (2) @(posedge clka);

        // basic: latency and back-to-back issue
        ready_mode = 0;
        rd0 = rd_count;
        start_xfer(8'h10, 9'd4);
        @(negedge clka);
        check("issue_c1", 32'(sram_enb), 32'd1);
        check("busy_c1", 32'(busy), 32'd1);
        @(negedge clka);
        check("mvalid_c2", 32'(m_valid), 32'd0);
        @(negedge clka);
        check("mvalid_c3", 32'(m_valid), 32'd1);
        @(negedge clka);
        @(posedge clka);
        #1;
        check("consec_reads", 32'(rd_count - rd0), 32'd4);
        wait_done(50);

        // wrap
        start_xfer(8'd126, 9'd4);
        wait_done(50);

        // backpressure
        ready_mode = 2;
        rd0 = rd_count;
        start_xfer(8'h40, 9'd10);
        repeat (20) @(posedge clka);
        #1;
        check("bp_reads", 32'(rd_count - rd0), 32'd4);
        ready_mode = 0;
        wait_done(100);

        // random ready over 64 words, crossing the wrap point
        ready_mode = 1;
        start_xfer(8'h50, 9'd64);
        wait_done(2000);
        ready_mode = 0;

        // zero-length transfer
        rd0 = rd_count;
        pulse_start(8'h33, 9'd0);
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            @(negedge clka);
            if (done) seen = 1'b1;
        end
        check("zero_done", 32'(done), 32'd1);
        repeat (3) @(negedge clka);
        check("zero_no_reads", 32'(rd_count - rd0), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);

        // start while busy is ignored
        start_xfer(8'h20, 9'd6);
        repeat (2) @(posedge clka);
        pulse_start(8'h70, 9'd3);
        wait_done(100);
        repeat (3) @(negedge clka);
        check("overlap_idle", 32'(busy), 32'd0);

        // reset during DRAIN
        ready_mode = 2;
        start_xfer(8'h30, 9'd3);
        repeat (8) @(posedge clka);
        #3 rstb = 1'b0;
        #1;
        check_idle_outputs("midrst");
        addr_q.delete();
        exp_q.delete();
        @(posedge clka);
        #1 rstb = 1'b1;
        ready_mode = 0;
        start_xfer(8'h00, 9'd2);
        wait_done(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
